// File: rtl/seq_detect_pkg.sv
// Shared constants and the detection-mode enum for the sequence detector.
package seq_detect_pkg;
   localparam int PAT_W_MIN = 2;
   localparam int PAT_W_MAX = 16;
   localparam int CNT_W_MAX = 16;

   typedef enum logic {
      MODE_NOOVL = 1'b0,
      MODE_OVL   = 1'b1
   } mode_e;
endpackage

// File: rtl/seq_detect_param_sat_counter.sv
// Saturating up-counter with synchronous clear; clear beats increment.
module sat_counter #(
   parameter int W = 8
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         inc,
   input  logic         clr,
   output logic [W-1:0] q
);
   // count up to all-ones and hold; clear or reset returns to zero
   always_ff @(posedge clk) begin
      if (!reset)                q <= '0;
      else if (clr)              q <= '0;
      else if (inc && (q != '1)) q <= q + 1'b1;
   end
endmodule

// File: rtl/seq_detect_param.sv
// Serial pattern detector with loadable pattern, overlap control and a
// saturating match counter.
module seq_detect_param
   import seq_detect_pkg::*;
#(
   parameter int                PAT_W   = 4,
   parameter int                CNT_W   = 8,
   parameter logic [PAT_W-1:0]  RST_PAT = PAT_W'(4'b1011)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             inbits,
   input  logic             in_valid,
   input  logic [PAT_W-1:0] pattern,
   input  logic             pat_load,
   input  logic             overlap_en,
   input  logic             count_clr,
   output logic             detect,
   output logic [CNT_W-1:0] match_count,
   output logic             count_sat
);
   localparam int               FILL_W    = $clog2(PAT_W + 1);
   localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(PAT_W);

   if (PAT_W < PAT_W_MIN || PAT_W > PAT_W_MAX) begin : g_bad_pat_w
      $error("seq_detect_param: PAT_W out of range");
   end
   if (CNT_W < 1 || CNT_W > CNT_W_MAX) begin : g_bad_cnt_w
      $error("seq_detect_param: CNT_W out of range");
   end

   logic [PAT_W-1:0]  pat_q, pat_d;
   logic [PAT_W-1:0]  hist, hist_d, hist_sh;
   logic [FILL_W-1:0] fill, fill_d, fill_inc;
   logic              detect_d;
   logic              accept;
   logic              match;
   mode_e             mode;

   // next-state: a load discards the bit; a non-overlapping match restarts the fill
   always_comb begin
      mode     = mode_e'(overlap_en);
      accept   = in_valid & ~pat_load;
      hist_sh  = {hist[PAT_W-2:0], inbits};
      fill_inc = (fill == FILL_FULL) ? FILL_FULL : fill + 1'b1;
      match    = accept && (fill_inc == FILL_FULL) && (hist_sh == pat_q);
      pat_d    = pat_q;
      hist_d   = hist;
      fill_d   = fill;
      detect_d = 1'b0;
      if (pat_load) begin
         pat_d  = pattern;
         hist_d = '0;
         fill_d = '0;
      end else if (accept) begin
         hist_d   = hist_sh;
         fill_d   = (match && mode == MODE_NOOVL) ? '0 : fill_inc;
         detect_d = match;
      end
   end

   // state registers; reset overrides every other control
   always_ff @(posedge clk) begin
      if (!reset) begin
         pat_q  <= RST_PAT;
         hist   <= '0;
         fill   <= '0;
         detect <= 1'b0;
      end else begin
         pat_q  <= pat_d;
         hist   <= hist_d;
         fill   <= fill_d;
         detect <= detect_d;
      end
   end

   sat_counter #(.W(CNT_W)) u_cnt (
      .clk   (clk),
      .reset (reset),
      .inc   (match),
      .clr   (count_clr),
      .q     (match_count)
   );

   assign count_sat = &match_count;
endmodule
